// File: rtl/fifo_control.sv
// Pointer, occupancy and flag controller for a dual-port FIFO memory.
// Accepts push/pop requests, drives memory strobes/addresses and reports status.
module fifo_control #(
    parameter int ADDR_WIDTH      = 8,
    parameter int ALMOST_FULL_TH  = 2**ADDR_WIDTH - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic                  write_enable,
    output logic                  read_enable,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  valid_out,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_TH_C = CW'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_TH_C = CW'(ALMOST_EMPTY_TH);

    // Status flags decoded from the registered occupancy
    always_comb begin
        full         = (count == DEPTH_C);
        empty        = (count == CW'(0));
        almost_full  = (count >= AF_TH_C);
        almost_empty = (count <= AE_TH_C);
    end

    // Request acceptance; strobes are held low while reset is asserted
    always_comb begin
        write_enable = 1'b0;
        read_enable  = 1'b0;
        if (reset_L) begin
            write_enable = push & ~full;
            read_enable  = pop & ~empty;
        end else begin
            write_enable = 1'b0;
            read_enable  = 1'b0;
        end
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= {ADDR_WIDTH{1'b0}};
            rd_ptr <= {ADDR_WIDTH{1'b0}};
            count  <= {CW{1'b0}};
        end else begin
            if (write_enable) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (read_enable) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({write_enable, read_enable})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Read-data valid tracking and sticky error capture
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_out     <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            valid_out     <= read_enable;
            overflow_err  <= overflow_err | (push & full);
            underflow_err <= underflow_err | (pop & empty);
        end
    end

endmodule

// File: tb/tb_fifo_control.sv
// Scoreboard bench for fifo_control (DEPTH=8) with a small behavioural memory
// and a queue-based reference model of FIFO occupancy, ordering and errors.
module tb_fifo_control;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF_TH = 6;
    localparam int AE_TH = 2;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          push;
    logic          pop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          write_enable;
    logic          read_enable;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          valid_out;
    logic          overflow_err;
    logic          underflow_err;

    logic [7:0]    din;
    logic [7:0]    dout;
    logic [7:0]    mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int ref_q[$];
    int exp_q[$];
    int ref_wr  = 0;
    int ref_rd  = 0;
    bit ref_ovf = 1'b0;
    bit ref_unf = 1'b0;
    bit ref_vld = 1'b0;

    fifo_control #(
        .ADDR_WIDTH(AW),
        .ALMOST_FULL_TH(AF_TH),
        .ALMOST_EMPTY_TH(AE_TH)
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .push(push),
        .pop(pop),
        .wr_ptr(wr_ptr),
        .rd_ptr(rd_ptr),
        .write_enable(write_enable),
        .read_enable(read_enable),
        .count(count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .valid_out(valid_out),
        .overflow_err(overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    // dual-port memory following the write/read-same-edge contract
    always @(posedge clk) begin
        if (write_enable) mem[wr_ptr] <= din;
        dout <= mem[rd_ptr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // monitor: every valid_out pops one expected data word
    always @(negedge clk) begin
        if (reset_L === 1'b1 && valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                chk("read_data", int'(dout), exp_q.pop_front());
            end
        end
    end

    task automatic check_state(input string tag);
        int n;
        n = ref_q.size();
        chk({tag, ".wr_ptr"}, int'(wr_ptr), ref_wr);
        chk({tag, ".rd_ptr"}, int'(rd_ptr), ref_rd);
        chk({tag, ".count"}, int'(count), n);
        chk({tag, ".full"}, int'(full), int'(n == DEPTH));
        chk({tag, ".empty"}, int'(empty), int'(n == 0));
        chk({tag, ".almost_full"}, int'(almost_full), int'(n >= AF_TH));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(n <= AE_TH));
        chk({tag, ".valid_out"}, int'(valid_out), int'(ref_vld));
        chk({tag, ".overflow_err"}, int'(overflow_err), int'(ref_ovf));
        chk({tag, ".underflow_err"}, int'(underflow_err), int'(ref_unf));
    endtask

    task automatic model_clear();
        ref_q.delete();
        exp_q.delete();
        ref_wr  = 0;
        ref_rd  = 0;
        ref_ovf = 1'b0;
        ref_unf = 1'b0;
        ref_vld = 1'b0;
    endtask

    // one clock of stimulus with strobe, model and state checks
    task automatic step(input bit p, input bit q, input int d, input string tag);
        bit acc_w;
        bit acc_r;
        @(negedge clk);
        push = p;
        pop  = q;
        din  = 8'(d);
        acc_w = p && (ref_q.size() < DEPTH);
        acc_r = q && (ref_q.size() > 0);
        #1;
        chk({tag, ".write_enable"}, int'(write_enable), int'(acc_w));
        chk({tag, ".read_enable"}, int'(read_enable), int'(acc_r));
        @(posedge clk);
        if (p && !acc_w) ref_ovf = 1'b1;
        if (q && !acc_r) ref_unf = 1'b1;
        if (acc_r) begin
            exp_q.push_back(ref_q.pop_front());
            ref_rd = (ref_rd + 1) % DEPTH;
        end
        if (acc_w) begin
            ref_q.push_back(d & 255);
            ref_wr = (ref_wr + 1) % DEPTH;
        end
        ref_vld = acc_r;
        #1;
        check_state(tag);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        push    = 1'b1;
        pop     = 1'b1;
        din     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        chk("rst.write_enable", int'(write_enable), 0);
        chk("rst.read_enable", int'(read_enable), 0);
        check_state("rst");
        @(negedge clk);
        push    = 1'b0;
        pop     = 1'b0;
        reset_L = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fill_data [8];
        fill_data = '{8'hFF, 8'hAF, 8'h17, 8'hB8, 8'h6A, 8'h01, 8'h02, 8'h03};
        do_reset();

        // fill, overflow, drain, underflow
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, fill_data[i], "fill");
        step(1'b1, 1'b0, 8'h55, "overfill");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 0, "drain");
        step(1'b0, 1'b1, 0, "underdrain");
        step(1'b0, 1'b0, 0, "idle");

        // wrap-around
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h10 + i, "wrap_push5");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 0, "wrap_pop5");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h20 + i, "wrap_push6");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 0, "wrap_pop6");

        // simultaneous push+pop at mid, full and empty
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h30 + i, "sim_pre");
        step(1'b1, 1'b1, 8'h40, "sim_mid");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h50 + i, "sim_fill");
        step(1'b1, 1'b1, 8'h60, "sim_full");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 0, "sim_drain");
        step(1'b1, 1'b1, 8'h70, "sim_empty");
        step(1'b0, 1'b1, 0, "sim_last");

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                 int'($urandom_range(0, 255)), "rand");
        end

        // asynchronous reset between clock edges
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h80 + i, "async_pre");
        push = 1'b1;
        pop  = 1'b1;
        #2;
        reset_L = 1'b0;
        #1;
        model_clear();
        chk("async.write_enable", int'(write_enable), 0);
        chk("async.read_enable", int'(read_enable), 0);
        check_state("async");
        @(negedge clk);
        push    = 1'b0;
        pop     = 1'b0;
        reset_L = 1'b1;
        chk("async.wr_ptr_zero", int'(wr_ptr), 0);
        step(1'b1, 1'b0, 8'h6A, "async_push");
        step(1'b0, 1'b1, 0, "async_pop");
        step(1'b0, 1'b0, 0, "async_idle");

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
